// File: rtl/adc_serial_capture.sv
// Master-side capture for a 12-bit serial ADC: frames chip-select, generates
// the serial clock, and presents each sample with a one-cycle ready strobe.
module adc_serial_capture #(
    parameter int WIDTH     = 12,
    parameter int LEAD_BITS = 4,
    parameter int HALF      = 2,
    parameter int QUIET     = 63
) (
    input  logic             clk,
    input  logic             reset,
    output logic             adc_clk,
    output logic             adc_cs,
    input  logic             adc_sd,
    output logic [WIDTH-1:0] data,
    output logic             ready
);
    localparam int N  = LEAD_BITS + WIDTH;
    localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;
    localparam int PW = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET - 1);
    localparam logic [PW-1:0] SAMPLE_PH  = PW'(HALF - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(2 * HALF - 1);
    localparam logic [PW-1:0] HALF_PH    = PW'(HALF);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [QW-1:0]    quiet_cnt_q, quiet_cnt_d;
    logic [PW-1:0]    ph_cnt_q, ph_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    // Only WIDTH bits are kept: leading bits fall off the top as data shifts in.
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             adc_cs_q, adc_cs_d;
    logic             adc_clk_q, adc_clk_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d     = state_q;
        quiet_cnt_d = quiet_cnt_q;
        ph_cnt_d    = ph_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;

        case (state_q)
            IDLE: begin
                if (quiet_cnt_q == QUIET_LAST) begin
                    state_d     = CONV;
                    quiet_cnt_d = '0;
                    ph_cnt_d    = '0;
                    bit_cnt_d   = '0;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + QW'(1);
                end
            end
            CONV: begin
                // Sample on the edge that ends the low half (adc_clk rises).
                if (ph_cnt_q == SAMPLE_PH) begin
                    shift_d = {shift_q[WIDTH-2:0], adc_sd};
                end
                if (ph_cnt_q == PH_LAST) begin
                    ph_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = DONE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + PW'(1);
                end
            end
            DONE: begin
                state_d     = IDLE;
                quiet_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered pins line
        // up cycle-for-cycle with the state they belong to.
        adc_cs_d  = (state_d != CONV);
        adc_clk_d = !((state_d == CONV) && (ph_cnt_d < HALF_PH));
        ready_d   = (state_d == DONE);
        data_d    = (state_d == DONE) ? shift_q : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            quiet_cnt_q <= '0;
            ph_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            adc_cs_q    <= 1'b1;
            adc_clk_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            quiet_cnt_q <= quiet_cnt_d;
            ph_cnt_q    <= ph_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            adc_cs_q    <= adc_cs_d;
            adc_clk_q   <= adc_clk_d;
            ready_q     <= ready_d;
        end
    end

    assign adc_cs  = adc_cs_q;
    assign adc_clk = adc_clk_q;
    assign ready   = ready_q;
    assign data    = data_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: default instance plus a HALF=1/QUIET=10 instance,
// each fed by a behavioural ADC, with a queue scoreboard and frame timing checks.
module tb_adc_serial_capture;
    localparam int N = 16;

    typedef struct packed {
        logic [15:0] word;
        logic [11:0] exp;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  reset_w  = 2'b11;
    logic [1:0]  adc_sd_w = 2'b00;
    logic [1:0]  adc_clk_w, adc_cs_w, ready_w;
    logic [11:0] data0, data1;

    adc_serial_capture #(.WIDTH(12), .LEAD_BITS(4), .HALF(2), .QUIET(63)) dut0 (
        .clk(clk), .reset(reset_w[0]), .adc_clk(adc_clk_w[0]), .adc_cs(adc_cs_w[0]),
        .adc_sd(adc_sd_w[0]), .data(data0), .ready(ready_w[0])
    );

    adc_serial_capture #(.WIDTH(12), .LEAD_BITS(4), .HALF(1), .QUIET(10)) dut1 (
        .clk(clk), .reset(reset_w[1]), .adc_clk(adc_clk_w[1]), .adc_cs(adc_cs_w[1]),
        .adc_sd(adc_sd_w[1]), .data(data1), .ready(ready_w[1])
    );

    int half_p[2]  = '{2, 1};
    int quiet_p[2] = '{63, 10};
    int period_p[2] = '{128, 43};
    int target[2]  = '{7, 3};

    // Frame 6 of dut0 (16'h0555) is aborted by a reset and never completes.
    stim_t tab0[8] = '{
        '{16'h0AC3, 12'hAC3}, '{16'hFFFF, 12'hFFF}, '{16'h0000, 12'h000},
        '{16'h0123, 12'h123}, '{16'h8F0E, 12'hF0E}, '{16'h0555, 12'h555},
        '{16'h0C3C, 12'hC3C}, '{16'h0001, 12'h001}
    };
    stim_t tab1[3] = '{
        '{16'h05A5, 12'h5A5}, '{16'hA5A5, 12'h5A5}, '{16'h0FFF, 12'hFFF}
    };
    stim_t dflt = '{16'hF000, 12'h000};

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];

    // ---------------- ADC model ----------------
    int          m_idx[2]    = '{0, 0};
    int          m_frames[2] = '{0, 0};
    int          m_bit[2]    = '{0, 0};
    logic [15:0] m_word[2];
    logic [1:0]  m_in   = 2'b00;
    logic [1:0]  m_pcs  = 2'b11;
    logic [1:0]  m_pclk = 2'b11;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            stim_t s;
            if (reset_w[i]) begin
                if (m_in[i]) begin
                    if (i == 0) void'(exp_q0.pop_back());
                    else        void'(exp_q1.pop_back());
                end
                m_in[i]     = 1'b0;
                adc_sd_w[i] = 1'b0;
            end else begin
                if (adc_cs_w[i]) m_in[i] = 1'b0;
                if (!adc_cs_w[i] && !adc_clk_w[i] && m_pclk[i]) begin
                    if (m_pcs[i]) begin
                        if (i == 0) begin
                            s = (m_idx[0] < 8) ? tab0[m_idx[0]] : dflt;
                            exp_q0.push_back(s.exp);
                        end else begin
                            s = (m_idx[1] < 3) ? tab1[m_idx[1]] : dflt;
                            exp_q1.push_back(s.exp);
                        end
                        m_idx[i]++;
                        m_word[i]   = s.word;
                        m_bit[i]    = 15;
                        m_in[i]     = 1'b1;
                        m_frames[i]++;
                    end
                    adc_sd_w[i] = m_word[i][m_bit[i]];
                    m_bit[i]--;
                end
            end
            m_pcs[i]  = adc_cs_w[i];
            m_pclk[i] = adc_clk_w[i];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input int d, input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h", d, name, act, exp);
        end
    endtask

    logic [1:0]  rst_d1   = 2'b00;
    logic [1:0]  armed    = 2'b00;
    logic [1:0]  p_cs     = 2'b11;
    logic [1:0]  p_clk    = 2'b11;
    logic [1:0]  p_rdy    = 2'b00;
    logic [1:0]  in_win   = 2'b00;
    logic [1:0]  has_prev = 2'b00;
    logic [11:0] p_data[2];
    int k[2], since[2], rises[2], low_run[2], hi_run[2], win_len[2];
    int rd_cnt[2] = '{0, 0};
    logic final_chk  = 1'b0;
    logic final_done = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic cs, ck, rd;
            logic [11:0] dt, e;
            cs = adc_cs_w[i];
            ck = adc_clk_w[i];
            rd = ready_w[i];
            dt = (i == 0) ? data0 : data1;
            if (rst_d1[i]) begin
                armed[i] = 1'b1;
                check(i, "rst_cs", cs, 1);
                check(i, "rst_clk", ck, 1);
                check(i, "rst_ready", rd, 0);
                check(i, "rst_data", dt, 0);
                k[i] = 0;
                since[i] = 0;
                has_prev[i] = 1'b0;
                in_win[i] = 1'b0;
            end else if (armed[i]) begin
                k[i]++;
                since[i]++;
                if (k[i] < quiet_p[i]) check(i, "idle_io", {cs, ck, rd}, 3'b110);
                if (k[i] == quiet_p[i]) check(i, "cs_fall", cs, 0);
                if (!rd) check(i, "data_hold", dt, p_data[i]);
                if (p_rdy[i]) check(i, "ready_width", rd, 0);
                if (rd) begin
                    rd_cnt[i]++;
                    check(i, "done_io", {cs, ck}, 2'b11);
                    if (has_prev[i]) check(i, "period", since[i], period_p[i]);
                    else check(i, "first_ready", k[i], quiet_p[i] + 2 * half_p[i] * N);
                    has_prev[i] = 1'b1;
                    since[i] = 0;
                    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                        check(i, "unexpected_ready", 1, 0);
                    end else begin
                        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check(i, "data", dt, e);
                    end
                end
                if (!cs) begin
                    if (p_cs[i]) begin
                        in_win[i] = 1'b1;
                        rises[i] = 0;
                        low_run[i] = 0;
                        hi_run[i] = 0;
                        win_len[i] = 0;
                    end
                    win_len[i]++;
                    if (!ck) begin
                        if (p_clk[i] && !p_cs[i]) check(i, "hi_half", hi_run[i], half_p[i]);
                        if (p_clk[i]) hi_run[i] = 0;
                        low_run[i]++;
                    end else begin
                        if (!p_clk[i]) begin
                            check(i, "lo_half", low_run[i], half_p[i]);
                            rises[i]++;
                            low_run[i] = 0;
                        end
                        hi_run[i]++;
                    end
                end else if (!p_cs[i] && in_win[i]) begin
                    check(i, "rises", rises[i], N);
                    check(i, "cs_low_len", win_len[i], 2 * half_p[i] * N);
                    check(i, "last_hi", hi_run[i], half_p[i]);
                    in_win[i] = 1'b0;
                end else begin
                    check(i, "clk_idle", ck, 1);
                end
            end
            p_cs[i]   = cs;
            p_clk[i]  = ck;
            p_rdy[i]  = rd;
            p_data[i] = dt;
            rst_d1[i] = reset_w[i];
        end
        if (final_chk && !final_done) begin
            for (int i = 0; i < 2; i++) check(i, "frames_done", int'(rd_cnt[i] >= target[i]), 1);
            final_done = 1'b1;
        end
    end

    // ---------------- sequence ----------------
    initial begin
        int c;
        repeat (5) @(posedge clk);
        #2 reset_w = 2'b00;

        c = 0;
        while (m_frames[0] < 6 && c < 2000) begin
            @(posedge clk);
            #3;
            c++;
        end
        if (m_frames[0] >= 6) begin
            repeat (32) @(posedge clk);
            #2 reset_w[0] = 1'b1;
            @(posedge clk);
            #2 reset_w[0] = 1'b0;
        end

        c = 0;
        while (!(rd_cnt[0] >= target[0] && rd_cnt[1] >= target[1]) && c < 3000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #2 final_chk = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
